stats_counter_updater: RTL and testbench

//  Read-modify-write engine for one port of the flow statistics counter RAM. Accepts
//  per-flow hit events (match address + increment) and host clear requests. Updates
//  the addressed counter through a single RAM port with 1-cycle read latency.

---
 rtl/stats_counter_updater.sv | 114 +++++++++++
 tb/tb_stats_counter_updater.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stats_counter_updater.sv
// Read-modify-write engine for one port of the flow statistics counter RAM; zeroes the table after reset.
// Optional macro STATS_SATURATE_EN: counters stick at all-ones on overflow instead of wrapping.
module stats_counter_updater #(
  parameter int C_MATCH_ADDR_WIDTH = 12,
  parameter int C_COUNTER_WIDTH    = 32,
  parameter int C_INC_WIDTH        = 16
) (
  input  logic                          axi_aclk,
  input  logic                          axi_resetn,
  input  logic                          hit_valid,
  output logic                          hit_ready,
  input  logic [C_MATCH_ADDR_WIDTH-1:0] hit_addr,
  input  logic [C_INC_WIDTH-1:0]        hit_inc,
  input  logic                          clr_valid,
  output logic                          clr_ready,
  input  logic [C_MATCH_ADDR_WIDTH-1:0] clr_addr,
  output logic [C_MATCH_ADDR_WIDTH-1:0] ram_addr,
  output logic                          ram_we,
  output logic [C_COUNTER_WIDTH-1:0]    ram_din,
  input  logic [C_COUNTER_WIDTH-1:0]    ram_dout,
  output logic                          init_done,
  output logic                          ovf_pulse
);

  localparam int AW = C_MATCH_ADDR_WIDTH;
  localparam int CW = C_COUNTER_WIDTH;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_RD, S_WR} state_t;

  state_t          state_q, state_nxt;
  logic            run_q;
  logic [AW-1:0]   sweep_q;
  logic [AW-1:0]   addr_q;
  logic [C_INC_WIDTH-1:0] inc_q;
  logic            clr_q;
  logic [CW:0]     sum_w;

  // run_q holds the outputs at their reset values for the first edge after release,
  // so the sweep never starts while reset is still being removed.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= S_INIT;
      run_q   <= 1'b0;
      sweep_q <= '0;
      addr_q  <= '0;
      inc_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      run_q   <= 1'b1;
      if (state_q == S_INIT && run_q) sweep_q <= sweep_q + 1'b1;
      if (state_q == S_IDLE) begin
        if (clr_valid) begin
          addr_q <= clr_addr;
          clr_q  <= 1'b1;
        end else if (hit_valid) begin
          addr_q <= hit_addr;
          inc_q  <= hit_inc;
          clr_q  <= 1'b0;
        end
      end
    end
  end

  // Carry-out lands in the extra top bit.
  assign sum_w = {1'b0, ram_dout} + (CW+1)'(inc_q);

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    state_nxt = state_q;
    hit_ready = 1'b0;
    clr_ready = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_din   = '0;
    ovf_pulse = 1'b0;
    init_done = (state_q != S_INIT);
    case (state_q)
      S_INIT: begin
        if (run_q) begin
          ram_we   = 1'b1;
          ram_addr = sweep_q;
          if (sweep_q == {AW{1'b1}}) state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        clr_ready = 1'b1;
        hit_ready = !clr_valid;
        if (clr_valid)      state_nxt = S_WR;
        else if (hit_valid) state_nxt = S_RD;
      end
      S_RD: begin
        ram_addr  = addr_q;
        state_nxt = S_WR;
      end
      S_WR: begin
        ram_addr  = addr_q;
        ram_we    = 1'b1;
        state_nxt = S_IDLE;
        if (!clr_q) begin
          ovf_pulse = sum_w[CW];
`ifdef STATS_SATURATE_EN
          ram_din = sum_w[CW] ? {CW{1'b1}} : sum_w[CW-1:0];
`else
          ram_din = sum_w[CW-1:0];
`endif
        end
      end
      default: state_nxt = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_stats_counter_updater.sv
// Directed bench for stats_counter_updater with a 1-cycle-latency RAM model.
// Expected overflow result follows STATS_SATURATE_EN when defined.
module tb_stats_counter_updater;

  logic        axi_aclk = 1'b0;
  logic        axi_resetn;
  logic        hit_valid, hit_ready;
  logic [11:0] hit_addr;
  logic [15:0] hit_inc;
  logic        clr_valid, clr_ready;
  logic [11:0] clr_addr;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_din, ram_dout;
  logic        init_done, ovf_pulse;

  logic [31:0] mem [0:4095];

  int n_vec = 0;
  int n_bad = 0;

`ifdef STATS_SATURATE_EN
  localparam logic [31:0] OVF_RESULT = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] OVF_RESULT = 32'h0000_0001;
`endif

  always #5 axi_aclk = ~axi_aclk;

  stats_counter_updater dut (
    .axi_aclk  (axi_aclk),
    .axi_resetn(axi_resetn),
    .hit_valid (hit_valid),
    .hit_ready (hit_ready),
    .hit_addr  (hit_addr),
    .hit_inc   (hit_inc),
    .clr_valid (clr_valid),
    .clr_ready (clr_ready),
    .clr_addr  (clr_addr),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .init_done (init_done),
    .ovf_pulse (ovf_pulse)
  );

  always @(posedge axi_aclk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hit_ready"}, 32'(hit_ready), 32'd0);
    check({tag, "_clr_ready"}, 32'(clr_ready), 32'd0);
    check({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
    check({tag, "_ram_we"},    32'(ram_we),    32'd0);
    check({tag, "_ram_din"},   ram_din,        32'd0);
    check({tag, "_init_done"}, 32'(init_done), 32'd0);
    check({tag, "_ovf_pulse"}, 32'(ovf_pulse), 32'd0);
  endtask

  // Called at the negedge where reset has just been released.
  task automatic sweep_check(input string tag);
    int wait_cyc = 0;
    int n = 0;
    int bad = 0;
    int nonzero = 0;
    logic [11:0] a;
    while (!ram_we && wait_cyc < 8) begin
      @(negedge axi_aclk);
      wait_cyc++;
    end
    while (ram_we && !init_done && n < 5000) begin
      a = n[11:0];
      if (ram_addr !== a || ram_din !== 32'd0) bad++;
      n++;
      @(negedge axi_aclk);
    end
    check({tag, "_len"},       32'(n),         32'd4096);
    check({tag, "_addr_data"}, 32'(bad),       32'd0);
    check({tag, "_init_done"}, 32'(init_done), 32'd1);
    for (int i = 0; i < 4096; i++) if (mem[i] !== 32'd0) nonzero++;
    check({tag, "_zeroed"},    32'(nonzero),   32'd0);
  endtask

  // Single hit starting at a negedge in IDLE; returns at the negedge of T+3.
  task automatic hit_txn(input string tag, input logic [11:0] a, input logic [15:0] inc,
                         input logic [31:0] exp_din, input logic exp_ovf);
    hit_valid = 1'b1; hit_addr = a; hit_inc = inc;
    #1 check({tag, "_ready_T"}, 32'(hit_ready), 32'd1);
    @(negedge axi_aclk);
    hit_valid = 1'b0;
    check({tag, "_rd_addr"}, 32'(ram_addr), 32'(a));
    check({tag, "_rd_we"},   32'(ram_we),   32'd0);
    check({tag, "_rd_ready"},32'(hit_ready),32'd0);
    @(negedge axi_aclk);
    check({tag, "_wr_we"},   32'(ram_we),    32'd1);
    check({tag, "_wr_addr"}, 32'(ram_addr),  32'(a));
    check({tag, "_wr_din"},  ram_din,        exp_din);
    check({tag, "_wr_ovf"},  32'(ovf_pulse), 32'(exp_ovf));
    @(negedge axi_aclk);
    check({tag, "_ready_T3"},32'(hit_ready), 32'd1);
    check({tag, "_ovf_T3"},  32'(ovf_pulse), 32'd0);
    check({tag, "_mem"},     mem[a],         exp_din);
  endtask

  initial begin
    axi_resetn = 1'b0;
    hit_valid = 1'b0; hit_addr = '0; hit_inc = '0;
    clr_valid = 1'b0; clr_addr = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'hA5A5_0000 | i;

    // Reset state, then the initial zeroing sweep.
    repeat (3) @(negedge axi_aclk);
    check_reset_outputs("rst");
    axi_resetn = 1'b1;
    sweep_check("init");

    // Plain hit, 100 + 64.
    mem[5] = 32'd100;
    hit_txn("hit5", 12'd5, 16'd64, 32'd164, 1'b0);

    // Two back-to-back hits to address 7; valid held high across both.
    hit_valid = 1'b1; hit_addr = 12'd7; hit_inc = 16'd1;
    #1 check("b2b_ready_T", 32'(hit_ready), 32'd1);
    @(negedge axi_aclk);
    check("b2b_ready_T1", 32'(hit_ready), 32'd0);
    @(negedge axi_aclk);
    check("b2b_ready_T2", 32'(hit_ready), 32'd0);
    check("b2b_din1", ram_din, 32'd1);
    @(negedge axi_aclk);
    check("b2b_ready_T3", 32'(hit_ready), 32'd1);
    @(negedge axi_aclk);
    hit_valid = 1'b0;
    check("b2b_rd2_addr", 32'(ram_addr), 32'd7);
    @(negedge axi_aclk);
    check("b2b_din2", ram_din, 32'd2);
    @(negedge axi_aclk);
    check("b2b_mem", mem[7], 32'd2);

    // Carry-out of the sum, and a zero increment on an all-ones counter.
    mem[11] = 32'hFFFF_FFFE;
    hit_txn("ovf", 12'd11, 16'd3, OVF_RESULT, 1'b1);
    mem[12] = 32'hFFFF_FFFF;
    hit_txn("inc0", 12'd12, 16'd0, 32'hFFFF_FFFF, 1'b0);

    // Clear and hit together: clear wins, hit follows.
    mem[9] = 32'd55;
    clr_valid = 1'b1; clr_addr = 12'd9;
    hit_valid = 1'b1; hit_addr = 12'd9; hit_inc = 16'd1;
    #1 check("clr_ready_T", 32'(clr_ready), 32'd1);
    check("clr_hit_ready_T", 32'(hit_ready), 32'd0);
    @(negedge axi_aclk);
    clr_valid = 1'b0;
    check("clr_we", 32'(ram_we), 32'd1);
    check("clr_addr", 32'(ram_addr), 32'd9);
    check("clr_din", ram_din, 32'd0);
    check("clr_busy", 32'(clr_ready), 32'd0);
    @(negedge axi_aclk);
    check("clr_then_hit_ready", 32'(hit_ready), 32'd1);
    check("clr_mem", mem[9], 32'd0);
    @(negedge axi_aclk);
    hit_valid = 1'b0;
    @(negedge axi_aclk);
    check("clr_hit_din", ram_din, 32'd1);
    @(negedge axi_aclk);
    check("clr_hit_mem", mem[9], 32'd1);

    // Reset asserted while the engine is in RD: no write, full re-sweep.
    mem[20] = 32'd7;
    hit_valid = 1'b1; hit_addr = 12'd20; hit_inc = 16'd5;
    @(negedge axi_aclk);
    hit_valid = 1'b0;
    axi_resetn = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) @(negedge axi_aclk);
    check("midrst_no_write", mem[20], 32'd7);
    for (int i = 0; i < 4096; i += 97) mem[i] = 32'h5A5A_0000 | i;
    axi_resetn = 1'b1;
    sweep_check("resweep");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
